// File: rtl/mult_op_integration_if.sv
// Value-in/value-out bundle for the 32x32 signed multiply operator.
// The master drives the operands and reads the product; the slave is the multiplier.
interface mult_op_integration_if;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [63:0] output1;

    modport master (output input1, output input2, input output1);
    modport slave  (input input1, input input2, output output1);
endinterface

// File: rtl/mult_op_integration.sv
// Registered 32x32 signed multiplier: input capture, radix-2 Booth engine (one step per cycle),
// product register. Recomputes whenever the captured operands differ from those in flight.
module mult_op_integration (
    input  logic                  clk,
    input  logic                  rst,
    mult_op_integration_if.slave  bus
);
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] a_r, b_r, op_a_r, op_b_r, q_r;
    logic [32:0] m_r, acc_r;
    logic        q_m1_r;
    logic [5:0]  cnt_r;
    logic [63:0] prod_r;

    logic [31:0] op_a_nxt_s, op_b_nxt_s, q_nxt_s;
    logic [32:0] m_nxt_s, acc_nxt_s, sum_s;
    logic        q_m1_nxt_s, mismatch_s;
    logic [5:0]  cnt_nxt_s;
    logic [63:0] prod_nxt_s;

    // 33-bit add/subtract keeps -2^31 operands exact
    function automatic logic [32:0] booth_sum(input logic [32:0] acc, input logic [32:0] m,
                                              input logic [1:0] pair);
        case (pair)
            2'b01:   return acc + m;
            2'b10:   return acc - m;
            default: return acc;
        endcase
    endfunction

    assign mismatch_s  = ({a_r, b_r} != {op_a_r, op_b_r});
    assign bus.output1 = prod_r;

    // Next-state and datapath next values
    always_comb begin
        state_nxt_s = state_r;
        op_a_nxt_s  = op_a_r;
        op_b_nxt_s  = op_b_r;
        m_nxt_s     = m_r;
        acc_nxt_s   = acc_r;
        q_nxt_s     = q_r;
        q_m1_nxt_s  = q_m1_r;
        cnt_nxt_s   = cnt_r;
        prod_nxt_s  = prod_r;
        sum_s       = acc_r;
        case (state_r)
            LOAD: begin
                op_a_nxt_s  = a_r;
                op_b_nxt_s  = b_r;
                m_nxt_s     = {a_r[31], a_r};
                acc_nxt_s   = 33'd0;
                q_nxt_s     = b_r;
                q_m1_nxt_s  = 1'b0;
                cnt_nxt_s   = 6'd0;
                state_nxt_s = RUN;
            end
            RUN: begin
                if (mismatch_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    sum_s      = booth_sum(acc_r, m_r, {q_r[0], q_m1_r});
                    acc_nxt_s  = {sum_s[32], sum_s[32:1]};
                    q_nxt_s    = {sum_s[0], q_r[31:1]};
                    q_m1_nxt_s = q_r[0];
                    cnt_nxt_s  = cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            DONE: begin
                if (mismatch_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    prod_nxt_s  = {acc_r[31:0], q_r};
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (mismatch_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = LOAD;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Input capture, Booth working registers and product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            op_a_r <= 32'd0;
            op_b_r <= 32'd0;
            m_r    <= 33'd0;
            acc_r  <= 33'd0;
            q_r    <= 32'd0;
            q_m1_r <= 1'b0;
            cnt_r  <= 6'd0;
            prod_r <= 64'd0;
        end else begin
            a_r    <= bus.input1;
            b_r    <= bus.input2;
            op_a_r <= op_a_nxt_s;
            op_b_r <= op_b_nxt_s;
            m_r    <= m_nxt_s;
            acc_r  <= acc_nxt_s;
            q_r    <= q_nxt_s;
            q_m1_r <= q_m1_nxt_s;
            cnt_r  <= cnt_nxt_s;
            prod_r <= prod_nxt_s;
        end
    end
endmodule

// File: tb/tb_mult_op_integration.sv
// Directed and random checks of the registered signed multiplier.
module tb_mult_op_integration;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mult_op_integration_if bus();

    mult_op_integration dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input int cycles);
        bus.input1 = a;
        bus.input2 = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        bus.input1 = 32'd7;
        bus.input2 = 32'd9;
        #1;
        total++;
        if (bus.output1 !== 64'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", bus.output1, 64'd0);
        end
        repeat (3) @(negedge clk);
        bus.input1 = 32'd5;
        bus.input2 = 32'd5;
        rst = 1'b0;
        n = 0;
        while (bus.output1 !== 64'h19 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.output1 !== 64'h19 || n > 36) begin
            bad++;
            $display("FAIL reset_release: got %h after %0d cycles want %h within 36",
                     bus.output1, n, 64'h19);
        end
    endtask

    task automatic test_signs();
        logic [31:0] av [3] = '{32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] bv [3] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'd5};
        logic [63:0] ev [3] = '{64'hFFFFFFFFFFFFFFE7, 64'h19, 64'hFFFFFFFFFFFFFFE7};
        for (int i = 0; i < 3; i++) begin
            apply(av[i], bv[i], 50);
            total++;
            if (bus.output1 !== ev[i]) begin
                bad++;
                $display("FAIL signs[%0d]: got %h want %h", i, bus.output1, ev[i]);
            end
        end
    endtask

    task automatic test_small();
        logic [31:0] av [4] = '{32'd0, 32'd1, 32'd8, 32'hFFFFFFF4};
        logic [31:0] bv [4] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'd6, 32'd6};
        logic [63:0] ev [4] = '{64'd0, 64'hFFFFFFFFFFFFFFFB, 64'h30, 64'hFFFFFFFFFFFFFFB8};
        for (int i = 0; i < 4; i++) begin
            apply(av[i], bv[i], 50);
            total++;
            if (bus.output1 !== ev[i]) begin
                bad++;
                $display("FAIL small[%0d]: got %h want %h", i, bus.output1, ev[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] av [3] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bv [3] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [63:0] ev [3] = '{64'h4000000000000000, 64'hC000000080000000, 64'd1};
        for (int i = 0; i < 3; i++) begin
            apply(av[i], bv[i], 50);
            total++;
            if (bus.output1 !== ev[i]) begin
                bad++;
                $display("FAIL extremes[%0d]: got %h want %h", i, bus.output1, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(32'd8, 32'd6, 10);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.output1 !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid_async: got %h want %h", bus.output1, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.output1 !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid_hold: got %h want %h", bus.output1, 64'd0);
        end
        repeat (45) @(negedge clk);
        total++;
        if (bus.output1 !== 64'h30) begin
            bad++;
            $display("FAIL reset_mid_recover: got %h want %h", bus.output1, 64'h30);
        end
    endtask

    task automatic test_abort();
        int n;
        bit seen21;
        seen21 = 1'b0;
        bus.input1 = 32'd3;
        bus.input2 = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.output1 === 64'd21) seen21 = 1'b1;
        end
        bus.input1 = 32'd9;
        bus.input2 = 32'd9;
        n = 0;
        while (bus.output1 !== 64'd81 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.output1 === 64'd21) seen21 = 1'b1;
        end
        total++;
        if (seen21) begin
            bad++;
            $display("FAIL abort_no21: aborted product 21 appeared, want never");
        end
        total++;
        if (bus.output1 !== 64'd81 || n > 36) begin
            bad++;
            $display("FAIL abort_latency: got %h after %0d cycles want %h within 36",
                     bus.output1, n, 64'd81);
        end
    endtask

    task automatic test_back_to_back();
        // Each pair is held far shorter than an operation; only the last may appear
        for (int i = 0; i < 5; i++) begin
            apply(32'd100 + 32'(i), 32'd3, 6);
            total++;
            if (bus.output1 !== 64'd81) begin
                bad++;
                $display("FAIL b2b_hold[%0d]: got %h want %h", i, bus.output1, 64'd81);
            end
        end
        apply(32'hFFFFFFFE, 32'd1000, 50);
        total++;
        if (bus.output1 !== 64'hFFFFFFFFFFFFF830) begin
            bad++;
            $display("FAIL b2b_final: got %h want %h", bus.output1, 64'hFFFFFFFFFFFFF830);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic signed [63:0] expv;
        logic [63:0] o37;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) a = {{16{a[15]}}, a[15:0]};
            expv = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            apply(a, b, 37);
            o37 = bus.output1;
            repeat (3) @(negedge clk);
            total++;
            if (o37 !== expv || bus.output1 !== expv) begin
                bad++;
                $display("FAIL random[%0d] %h*%h: got %h then %h want %h",
                         i, a, b, o37, bus.output1, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_small();
        test_extremes();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
